// File: rtl/adder_bist_pkg.sv
// Shared constants, FSM encoding and corner-vector table for the adder BIST engine.
// Corner vectors are only used when ADDER_BIST_CORNER_EN is defined.
package adder_bist_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int FAIL_RC  = 0;
  localparam int FAIL_CBA = 1;
  localparam int FAIL_CLA = 2;
  localparam int FAIL_CSA = 3;

  localparam int CORNER_COUNT = 4;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } vector_t;

  // Overflow, sign crossing, all-ones carry chain and a mixed pattern.
  function automatic vector_t corner_vector(input logic [1:0] idx);
    vector_t v;
    case (idx)
      2'd0:    v = '{a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0};
      2'd1:    v = '{a: 32'h80000000, b: 32'hFFFFFFFF, cin: 1'b0};
      2'd2:    v = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, cin: 1'b0};
      default: v = '{a: 32'h5A3F2D1C, b: 32'h4C7E9A8B, cin: 1'b1};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit right-shifting Galois LFSR used as an operand source; load reseeds, step advances once.
module bist_lfsr32
  import adder_bist_pkg::*;
#(
  parameter logic [WIDTH-1:0] SEED = 32'h00000001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {1'b0, state[WIDTH-1:1]} ^ (state[0] ? LFSR_MASK : '0);
    end
  end

endmodule

// File: rtl/adder_bist_engine.sv
// BIST engine driving four adders in parallel and scoring them against a golden a+b+cin.
// Define ADDER_BIST_CORNER_EN to prepend the fixed corner vectors to each run.
module adder_bist_engine
  import adder_bist_pkg::*;
#(
  parameter int               NUM_VECTORS   = 256,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] SEED_A        = 32'hACE12B3F,
  parameter logic [WIDTH-1:0] SEED_B        = 32'h5EED0F17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             cin_out,
  input  logic [WIDTH-1:0] sum_rc,
  input  logic [WIDTH-1:0] sum_cba,
  input  logic [WIDTH-1:0] sum_cla,
  input  logic [WIDTH-1:0] sum_csa,
  input  logic             cout_rc,
  input  logic             cout_cba,
  input  logic             cout_cla,
  input  logic             cout_csa,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      success_count,
  output logic [15:0]      failure_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [3:0]       fail_mask
);

  state_e           fsm_state;
  logic [15:0]      vec_idx;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             use_corner;
  vector_t          src;
  logic [WIDTH:0]   golden;
  logic [3:0]       mismatch;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lfsr_load = ((fsm_state == ST_IDLE) || (fsm_state == ST_DONE)) && start;

`ifdef ADDER_BIST_CORNER_EN
  assign use_corner = (vec_idx < 16'(CORNER_COUNT));
`else
  assign use_corner = 1'b0;
`endif

  // LFSRs hold still while table vectors are being consumed.
  assign lfsr_step = (fsm_state == ST_CHECK) && !use_corner;

  bist_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .state (lfsr_a)
  );

  bist_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .state (lfsr_b)
  );

  always_comb begin
    src = '{a: lfsr_a, b: lfsr_b, cin: lfsr_a[WIDTH-1] ^ lfsr_b[0]};
`ifdef ADDER_BIST_CORNER_EN
    if (use_corner) src = corner_vector(vec_idx[1:0]);
`endif
  end

  assign golden = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, cin_out};

  // Case inequality so X/Z on any adder output scores as a mismatch.
  always_comb begin
    mismatch           = '0;
    mismatch[FAIL_RC]  = ({cout_rc,  sum_rc}  !== golden);
    mismatch[FAIL_CBA] = ({cout_cba, sum_cba} !== golden);
    mismatch[FAIL_CLA] = ({cout_cla, sum_cla} !== golden);
    mismatch[FAIL_CSA] = ({cout_csa, sum_csa} !== golden);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state     <= ST_IDLE;
      vec_idx       <= '0;
      settle_cnt    <= '0;
      a_out         <= '0;
      b_out         <= '0;
      cin_out       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      success_count <= '0;
      failure_count <= '0;
      fail_valid    <= 1'b0;
      fail_a        <= '0;
      fail_b        <= '0;
      fail_cin      <= 1'b0;
      fail_mask     <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fsm_state     <= ST_DRIVE;
            vec_idx       <= '0;
            success_count <= '0;
            failure_count <= '0;
            fail_valid    <= 1'b0;
            fail_a        <= '0;
            fail_b        <= '0;
            fail_cin      <= 1'b0;
            fail_mask     <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            busy          <= 1'b1;
          end
        end
        ST_DRIVE: begin
          a_out      <= src.a;
          b_out      <= src.b;
          cin_out    <= src.cin;
          settle_cnt <= 4'(SETTLE_CYCLES);
          fsm_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) fsm_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch == '0) begin
            success_count <= sat_inc(success_count);
          end else begin
            failure_count <= sat_inc(failure_count);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_out;
              fail_b     <= b_out;
              fail_cin   <= cin_out;
              fail_mask  <= mismatch;
            end
          end
          if (vec_idx == 16'(NUM_VECTORS - 1)) begin
            fsm_state <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (mismatch == '0) && (failure_count == '0);
          end else begin
            vec_idx   <= vec_idx + 16'd1;
            fsm_state <= ST_DRIVE;
          end
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_engine.sv
// Self-checking bench for adder_bist_engine: behavioural adders with injectable faults
// and a spec-level model of the vector sequence and expected statistics.
module tb_adder_bist_engine;

  localparam int          NV     = 16;
  localparam int          SC     = 2;
  localparam int          PER    = SC + 2;
  localparam logic [31:0] SEED_A = 32'hACE12B3F;
  localparam logic [31:0] SEED_B = 32'h5EED0F17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_out, b_out;
  logic        cin_out;
  logic [31:0] sum_rc, sum_cba, sum_cla, sum_csa;
  logic        cout_rc, cout_cba, cout_cla, cout_csa;
  logic        busy, done, pass, fail_valid, fail_cin;
  logic [15:0] success_count, failure_count;
  logic [31:0] fail_a, fail_b;
  logic [3:0]  fail_mask;

  int checks = 0;
  int failures = 0;

  // Fault injection: 0 none, 1 sum_cla[0] stuck-0, 2 sum_rc[param] stuck-1, 3 cout_csa X on vector param.
  int          fkind = 0;
  int          fparam = 0;
  logic [31:0] xa = '0, xb = '0;
  logic        xc = 1'b0;

  logic [31:0] va[NV];
  logic [31:0] vb[NV];
  logic        vc[NV];

  typedef struct {
    int          kind;
    int          param;
    int          exp_succ;
    int          exp_fail;
    logic        exp_fv;
    logic [3:0]  exp_mask;
    logic [31:0] exp_fa;
    logic [31:0] exp_fb;
    logic        exp_fcin;
    logic        exp_pass;
  } scen_t;

  localparam int NSC = 5;
  scen_t sc[NSC];

  adder_bist_engine #(
    .NUM_VECTORS   (NV),
    .SETTLE_CYCLES (SC),
    .SEED_A        (SEED_A),
    .SEED_B        (SEED_B)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a_out         (a_out),
    .b_out         (b_out),
    .cin_out       (cin_out),
    .sum_rc        (sum_rc),
    .sum_cba       (sum_cba),
    .sum_cla       (sum_cla),
    .sum_csa       (sum_csa),
    .cout_rc       (cout_rc),
    .cout_cba      (cout_cba),
    .cout_cla      (cout_cla),
    .cout_csa      (cout_csa),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .success_count (success_count),
    .failure_count (failure_count),
    .fail_valid    (fail_valid),
    .fail_a        (fail_a),
    .fail_b        (fail_b),
    .fail_cin      (fail_cin),
    .fail_mask     (fail_mask)
  );

  always #5 clk = ~clk;

  // Behavioural adders with optional faults.
  always_comb begin
    logic [32:0] g;
    g = {1'b0, a_out} + {1'b0, b_out} + {32'b0, cin_out};
    {cout_rc, sum_rc}   = g;
    {cout_cba, sum_cba} = g;
    {cout_cla, sum_cla} = g;
    {cout_csa, sum_csa} = g;
    if (fkind == 1) sum_cla[0] = 1'b0;
    if (fkind == 2) sum_rc[fparam[4:0]] = 1'b1;
    if (fkind == 3 && a_out == xa && b_out == xb && cin_out == xc) begin
      cout_csa = 1'bx;
      // A two-state simulator collapses X to 0/1; keep it a genuine mismatch there too.
      if (cout_csa === g[32]) cout_csa = ~g[32];
    end
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic gen_vectors();
    logic [31:0] la, lb;
    int first;
    la = SEED_A;
    lb = SEED_B;
    first = 0;
`ifdef ADDER_BIST_CORNER_EN
    va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001; vc[0] = 1'b0;
    va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; vc[1] = 1'b0;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF; vc[2] = 1'b0;
    va[3] = 32'h5A3F2D1C; vb[3] = 32'h4C7E9A8B; vc[3] = 1'b1;
    first = (NV < 4) ? NV : 4;
`endif
    for (int i = first; i < NV; i++) begin
      va[i] = la;
      vb[i] = lb;
      vc[i] = la[31] ^ lb[0];
      la = lfsr_next(la);
      lb = lfsr_next(lb);
    end
  endtask

  function automatic logic [3:0] model_mask(input int kind, input int p, input int i);
    logic [32:0] g;
    logic [3:0]  m;
    g = 33'(va[i]) + 33'(vb[i]) + 33'(vc[i]);
    m = 4'b0000;
    if (kind == 1) m[2] = g[0];
    if (kind == 2) m[0] = !g[p];
    if (kind == 3) m[3] = (i == p);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_a_out"}, 64'(a_out), 64'd0);
    chk({tag, "_b_out"}, 64'(b_out), 64'd0);
    chk({tag, "_cin_out"}, 64'(cin_out), 64'd0);
    chk({tag, "_success"}, 64'(success_count), 64'd0);
    chk({tag, "_failure"}, 64'(failure_count), 64'd0);
    chk({tag, "_fail_valid"}, 64'(fail_valid), 64'd0);
    chk({tag, "_fail_a"}, 64'(fail_a), 64'd0);
    chk({tag, "_fail_mask"}, 64'(fail_mask), 64'd0);
  endtask

  task automatic apply_fault(input int si);
    fkind  = sc[si].kind;
    fparam = sc[si].param;
    if (fkind == 3) begin
      xa = va[fparam];
      xb = vb[fparam];
      xc = vc[fparam];
    end
  endtask

  // Pulses (or holds) start, then follows the run checking each CHECK-cycle operand.
  task automatic run_once(input bit hold);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 4 * NV * PER) begin
      if ((cyc % PER) == PER - 1 && (cyc / PER) < NV) begin
        chk("a_out_vec", 64'(a_out), 64'(va[cyc / PER]));
        chk("b_out_vec", 64'(b_out), 64'(vb[cyc / PER]));
        chk("cin_out_vec", 64'(cin_out), 64'(vc[cyc / PER]));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("busy_cycles", 64'(cyc), 64'(NV * PER));
  endtask

  task automatic check_result(input int si);
    chk("done", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("pass", 64'(pass), 64'(sc[si].exp_pass));
    chk("success_count", 64'(success_count), 64'(sc[si].exp_succ));
    chk("failure_count", 64'(failure_count), 64'(sc[si].exp_fail));
    chk("fail_valid", 64'(fail_valid), 64'(sc[si].exp_fv));
    chk("fail_mask", 64'(fail_mask), 64'(sc[si].exp_mask));
    chk("fail_a", 64'(fail_a), 64'(sc[si].exp_fa));
    chk("fail_b", 64'(fail_b), 64'(sc[si].exp_fb));
    chk("fail_cin", 64'(fail_cin), 64'(sc[si].exp_fcin));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gen_vectors();

    sc[0] = '{kind: 0, param: 0, default: 0};
    sc[1] = '{kind: 1, param: 0, default: 0};
    sc[2] = '{kind: 2, param: int'($urandom_range(0, 31)), default: 0};
    sc[3] = '{kind: 3, param: int'($urandom_range(0, NV - 1)), default: 0};
    sc[4] = '{kind: 2, param: int'($urandom_range(0, 31)), default: 0};
    for (int s = 0; s < NSC; s++) begin
      for (int i = 0; i < NV; i++) begin
        logic [3:0] m;
        m = model_mask(sc[s].kind, sc[s].param, i);
        if (m == 4'b0000) begin
          sc[s].exp_succ++;
        end else begin
          sc[s].exp_fail++;
          if (!sc[s].exp_fv) begin
            sc[s].exp_fv   = 1'b1;
            sc[s].exp_mask = m;
            sc[s].exp_fa   = va[i];
            sc[s].exp_fb   = vb[i];
            sc[s].exp_fcin = vc[i];
          end
        end
      end
      sc[s].exp_pass = (sc[s].exp_fail == 0);
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    for (int s = 0; s < NSC; s++) begin
      apply_fault(s);
      run_once(1'b0);
      check_result(s);
    end

    // start held high through a whole run, then restart from DONE.
    apply_fault(0);
    run_once(1'b1);
    check_result(0);
    @(posedge clk);
    #1;
    chk("restart_done_low", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_success_clr", 64'(success_count), 64'd0);
    start = 1'b0;

    // Abort during vector 5.
    repeat (5 * PER + 1) @(posedge clk);
    #1;
    chk("pre_abort_a_out", 64'(a_out), 64'(va[5]));
    chk("pre_abort_success", 64'(success_count), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;

    // Rerun must reproduce the same operand sequence.
    run_once(1'b0);
    check_result(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
